// File: rtl/lut4_sbox_seq.sv
// lut4_sbox_seq
//   Sequenced 16-entry, 4-bit S-box substitution of a 32-bit word. Each of the
//   eight index nibbles of rs1 selects one entry from a 16-entry table that is
//   split across two 32-bit operands (lut_lo = entries 0..7, lut_hi = 8..15).
//   The engine runs a low pass and a high pass of the split lut4 operation and
//   ORs them. With FAST=1 both passes are evaluated in a single cycle.
//
// Ports
//   clk         clock, rising edge
//   reset       synchronous, active-high
//   req_valid   request operands valid
//   req_ready   engine idle and able to take a request
//   req_rs1     eight 4-bit indices, nibble n = req_rs1[4n+:4]
//   req_lut_lo  table entries 0..7, entry k = req_lut_lo[4k+:4]
//   req_lut_hi  table entries 8..15, entry 8+k = req_lut_hi[4k+:4]
//   rsp_valid   rsp_rd holds a completed result
//   rsp_ready   consumer accepts the result
//   rsp_rd      substituted word (0 whenever rsp_valid is low)
//   busy        engine is not idle (always equals !req_ready)
//
// All outputs are decoded from registered state only; no input reaches an
// output combinationally.

module lut4_sbox_seq #(
    parameter bit FAST = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_lut_lo,
    input  logic [31:0] req_lut_hi,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rd,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_q;
    state_t      state_nxt;

    logic [31:0] rs1_p0;
    logic [31:0] lo_p0;
    logic [31:0] hi_p0;
    logic [31:0] acc_p1;

    logic [31:0] pass_lo;
    logic [31:0] pass_hi;
    logic        req_hs;

    // One lut4 pass: a nibble whose index MSB disagrees with the selected
    // half yields zero, so the low and high passes never overlap and can be
    // merged with a plain OR.
    function automatic logic [31:0] lut4_pass(input logic [31:0] x,
                                              input logic [31:0] t,
                                              input logic        h);
        logic [31:0] r;
        logic [3:0]  idx;
        r = '0;
        for (int n = 0; n < 8; n++) begin
            idx = x[4*n +: 4];
            if (h == idx[3]) begin
                r[4*n +: 4] = t[{idx[2:0], 2'b00} +: 4];
            end
        end
        return r;
    endfunction

    assign req_hs  = req_valid && (state_q == IDLE);
    assign pass_lo = lut4_pass(rs1_p0, lo_p0, 1'b0);
    assign pass_hi = lut4_pass(rs1_p0, hi_p0, 1'b1);

    // ---- Stage p0: operand capture on request handshake ----
    // Operands are overwritten by every accepted request, so a reset needs no
    // clearing here; stale values are never observed.
    always_ff @(posedge clk) begin
        if (req_hs) begin
            rs1_p0 <= req_rs1;
            lo_p0  <= req_lut_lo;
            hi_p0  <= req_lut_hi;
        end
    end

    // ---- Stage p1: pass accumulation ----
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_p1 <= '0;
        end else begin
            case (state_q)
                LO:      acc_p1 <= FAST ? (pass_lo | pass_hi) : pass_lo;
                HI:      acc_p1 <= acc_p1 | pass_hi;
                default: acc_p1 <= acc_p1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_nxt = LO;
            LO:      state_nxt = FAST ? DONE : HI;
            HI:      state_nxt = DONE;
            DONE:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == IDLE);
        busy      = (state_q != IDLE);
        rsp_valid = (state_q == DONE);
        rsp_rd    = (state_q == DONE) ? acc_p1 : 32'h0;
    end

endmodule

// File: tb/tb_lut4_sbox_seq.sv
// Testbench for lut4_sbox_seq. Two instances are driven: dut0 with FAST=0 and
// dut1 with FAST=1. A scoreboard compares every cycle against a 16-entry
// table lookup model; directed sections add literal expectations.

module tb_lut4_sbox_seq;

    logic        clk = 1'b0;
    logic [1:0]  reset;
    logic [1:0]  req_valid;
    logic [1:0]  rsp_ready;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [1:0]  busy;
    logic [31:0] rs1 [2];
    logic [31:0] lo  [2];
    logic [31:0] hi  [2];
    logic [31:0] rsp_rd [2];

    int n_cmp = 0;
    int n_bad = 0;
    int n_acc [2];
    int n_rsp [2];
    int n_abort [2];

    logic [31:0] exp_q0 [$];
    logic [31:0] exp_q1 [$];

    always #5 clk = ~clk;

    lut4_sbox_seq #(.FAST(1'b0)) dut0 (
        .clk(clk), .reset(reset[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_rs1(rs1[0]), .req_lut_lo(lo[0]), .req_lut_hi(hi[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rd(rsp_rd[0]), .busy(busy[0])
    );

    lut4_sbox_seq #(.FAST(1'b1)) dut1 (
        .clk(clk), .reset(reset[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_rs1(rs1[1]), .req_lut_lo(lo[1]), .req_lut_hi(hi[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rd(rsp_rd[1]), .busy(busy[1])
    );

    // Reference: assemble the full 16-entry table and look each nibble up.
    function automatic logic [31:0] sbox_ref(input logic [31:0] x,
                                             input logic [31:0] l,
                                             input logic [31:0] h);
        logic [3:0]  tbl [16];
        logic [31:0] r;
        logic [3:0]  idx;
        for (int k = 0; k < 8; k++) begin
            tbl[k]     = l[4*k +: 4];
            tbl[k + 8] = h[4*k +: 4];
        end
        r = '0;
        for (int n = 0; n < 8; n++) begin
            idx = x[4*n +: 4];
            r[4*n +: 4] = tbl[idx];
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int qsize(input int w);
        return (w == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    // Per-cycle scoreboard, sampled on the falling edge so it sees exactly the
    // values the next rising edge will act on.
    task automatic sb_tick(input int w);
        logic [31:0] head;
        if (reset[w]) begin
            n_abort[w] += qsize(w);
            if (w == 0) exp_q0.delete(); else exp_q1.delete();
        end else begin
            check("busy_vs_ready", {31'h0, busy[w]}, {31'h0, ~req_ready[w]});
            if (rsp_valid[w]) begin
                check("ready_in_done", {31'h0, req_ready[w]}, 32'h0);
                if (qsize(w) == 0) begin
                    check("rsp_unexpected", {31'h0, rsp_valid[w]}, 32'h0);
                end else begin
                    head = (w == 0) ? exp_q0[0] : exp_q1[0];
                    check("rsp_rd_model", rsp_rd[w], head);
                    if (rsp_ready[w]) begin
                        if (w == 0) void'(exp_q0.pop_front());
                        else        void'(exp_q1.pop_front());
                        n_rsp[w]++;
                    end
                end
            end else begin
                check("rsp_rd_idle", rsp_rd[w], 32'h0);
            end
            if (req_valid[w] && req_ready[w]) begin
                if (w == 0) exp_q0.push_back(sbox_ref(rs1[w], lo[w], hi[w]));
                else        exp_q1.push_back(sbox_ref(rs1[w], lo[w], hi[w]));
                n_acc[w]++;
            end
        end
    endtask

    // Called just after a rising edge; returns just after the handshake edge.
    task automatic send(input int w, input logic [31:0] a, input logic [31:0] l,
                        input logic [31:0] h);
        int ok;
        rs1[w] = a; lo[w] = l; hi[w] = h;
        req_valid[w] = 1'b1;
        ok = 0;
        for (int i = 0; i < 50 && ok == 0; i++) begin
            @(negedge clk);
            ok = int'(req_ready[w]);
            @(posedge clk); #1;
        end
        req_valid[w] = 1'b0;
        if (ok == 0) check("req_timeout", 32'h0, 32'h1);
    endtask

    task automatic wait_rsp(input int w, output int n);
        n = 0;
        while (!rsp_valid[w] && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!rsp_valid[w]) check("rsp_timeout", 32'h0, 32'h1);
    endtask

    int lat;
    int target;
    int cyc;

    initial begin
        reset = 2'b11; req_valid = 2'b00; rsp_ready = 2'b00;
        for (int w = 0; w < 2; w++) begin
            rs1[w] = '0; lo[w] = '0; hi[w] = '0;
            n_acc[w] = 0; n_rsp[w] = 0; n_abort[w] = 0;
        end

        fork
            forever begin
                @(negedge clk);
                sb_tick(0);
                sb_tick(1);
            end
        join_none

        // Model pins
        check("model_lo", sbox_ref(32'h76543210, 32'h89ABCDEF, 32'h01234567), 32'h89ABCDEF);
        check("model_hi", sbox_ref(32'hFEDCBA98, 32'h89ABCDEF, 32'h01234567), 32'h01234567);
        check("model_mix", sbox_ref(32'h0F0F0F0F, 32'h89ABCDEF, 32'h01234567), 32'hF0F0F0F0);

        repeat (2) @(posedge clk);
        #1;
        reset = 2'b00;
        for (int w = 0; w < 2; w++) begin
            check("rst_req_ready", {31'h0, req_ready[w]}, 32'h1);
            check("rst_rsp_valid", {31'h0, rsp_valid[w]}, 32'h0);
            check("rst_rsp_rd", rsp_rd[w], 32'h0);
            check("rst_busy", {31'h0, busy[w]}, 32'h0);
        end

        // lut_lo-only lookup, FAST=0
        rsp_ready[0] = 1'b1;
        send(0, 32'h76543210, 32'h89ABCDEF, 32'h01234567);
        wait_rsp(0, lat);
        check("lat_fast0", lat, 2);
        check("rsp_lo_only", rsp_rd[0], 32'h89ABCDEF);
        @(posedge clk); #1;

        // lut_hi-only lookup
        send(0, 32'hFEDCBA98, 32'h89ABCDEF, 32'h01234567);
        wait_rsp(0, lat);
        check("lat_fast0_b", lat, 2);
        check("rsp_hi_only", rsp_rd[0], 32'h01234567);
        @(posedge clk); #1;

        // Mixed halves, FAST=1
        rsp_ready[1] = 1'b1;
        send(1, 32'h0F0F0F0F, 32'h89ABCDEF, 32'h01234567);
        wait_rsp(1, lat);
        check("lat_fast1", lat, 1);
        check("rsp_mixed", rsp_rd[1], 32'hF0F0F0F0);
        @(posedge clk); #1;

        // Back-pressure with live, changing requests on the input
        rsp_ready[0] = 1'b0;
        send(0, 32'h76543210, 32'h89ABCDEF, 32'h01234567);
        wait_rsp(0, lat);
        req_valid[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rs1[0] = $urandom; lo[0] = $urandom; hi[0] = $urandom;
            @(negedge clk);
            check("bp_rsp_rd", rsp_rd[0], 32'h89ABCDEF);
            check("bp_req_ready", {31'h0, req_ready[0]}, 32'h0);
            check("bp_rsp_valid", {31'h0, rsp_valid[0]}, 32'h1);
            @(posedge clk); #1;
        end
        rs1[0] = 32'hFEDCBA98; lo[0] = 32'h89ABCDEF; hi[0] = 32'h01234567;
        rsp_ready[0] = 1'b1;
        @(posedge clk); #1;
        check("bp_ready_after_rsp", {31'h0, req_ready[0]}, 32'h1);
        check("bp_valid_after_rsp", {31'h0, rsp_valid[0]}, 32'h0);
        @(posedge clk); #1;
        check("bp_next_accepted", {31'h0, busy[0]}, 32'h1);
        req_valid[0] = 1'b0;
        wait_rsp(0, lat);
        check("bp_next_lat", lat, 2);
        check("bp_next_rsp", rsp_rd[0], 32'h01234567);
        @(posedge clk); #1;

        // Reset while in HI
        send(0, 32'h76543210, 32'hFFFFFFFF, 32'hFFFFFFFF);
        @(posedge clk); #1;
        reset[0] = 1'b1;
        @(posedge clk); #1;
        reset[0] = 1'b0;
        check("mrst_req_ready", {31'h0, req_ready[0]}, 32'h1);
        check("mrst_rsp_valid", {31'h0, rsp_valid[0]}, 32'h0);
        check("mrst_rsp_rd", rsp_rd[0], 32'h0);
        check("mrst_busy", {31'h0, busy[0]}, 32'h0);
        @(posedge clk); #1;
        check("mrst_no_rsp", {31'h0, rsp_valid[0]}, 32'h0);
        send(0, 32'h0F0F0F0F, 32'h89ABCDEF, 32'h01234567);
        wait_rsp(0, lat);
        check("mrst_after_rsp", rsp_rd[0], 32'hF0F0F0F0);
        @(posedge clk); #1;

        // Random regression, each FAST value in turn
        for (int w = 0; w < 2; w++) begin
            target = n_acc[w] + 1000;
            cyc = 0;
            while ((n_acc[w] < target || qsize(w) != 0 || rsp_valid[w]) && cyc < 20000) begin
                req_valid[w] = (n_acc[w] < target) ? ($urandom_range(0, 3) != 0) : 1'b0;
                rs1[w] = $urandom; lo[w] = $urandom; hi[w] = $urandom;
                rsp_ready[w] = ($urandom_range(0, 2) != 0);
                @(posedge clk); #1;
                cyc++;
            end
            req_valid[w] = 1'b0;
            check("rand_accepted", n_acc[w], target);
        end

        for (int w = 0; w < 2; w++) begin
            check("rsp_count", n_rsp[w], n_acc[w] - n_abort[w]);
            check("queue_drained", qsize(w), 0);
        end
        check("one_abort", n_abort[0], 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
